// File: rtl/a2d_spi_resp_pkg.sv
// Shared types and constants for the A2D SPI responder.
// Frame geometry, FSM encoding and LFSR seed used by a2d_spi_resp.
package a2d_resp_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} resp_state_t;

    localparam int          FRAME_BITS = 16;
    localparam int          CHAN_MSB   = 13;
    localparam int          CHAN_LSB   = 11;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

endpackage

// File: rtl/a2d_spi_resp_spi_in_sync.sv
// Double-flop synchronizer for one async SPI pin, plus a third flop for edge detect.
// RST_VAL sets the idle level the chain holds while in reset.
module spi_in_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [2:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= {3{RST_VAL}};
        else     ff <= {ff[1:0], din};
    end

    assign dout = ff[1];
    assign rise = ff[1] & ~ff[2];
    assign fall = ~ff[1] & ff[2];

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D: command in one frame, sample out the next.
// Optional sample noise via `A2D_RESP_NOISE_EN (16-bit LFSR added with saturation).
module a2d_spi_resp
    import a2d_resp_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int DW         = 12,
    parameter int RST_CH     = 0,
    parameter int NOISE_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SS_n,
    input  logic                   SCLK,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic [NUM_CH*DW-1:0]   ana_vals,
    output logic [FRAME_BITS-1:0]  last_cmd,
    output logic                   cmd_vld,
    output logic                   frame_err,
    output logic [15:0]            frame_cnt
);

    if (NUM_CH < 1 || NUM_CH > 8 || DW > FRAME_BITS || NOISE_BITS < 1 || NOISE_BITS > DW) begin : g_cfg_err
        $error("a2d_spi_resp: unsupported parameter set");
    end

    logic ss_n_s, ss_rise, ss_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s;

    spi_in_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(SS_n), .dout(ss_n_s), .rise(ss_rise), .fall(ss_fall));
    spi_in_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(SCLK), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_in_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(MOSI), .dout(mosi_s), .rise(), .fall());

    resp_state_t           state;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] rx_shft, tx_shft, nxt_word;
    logic [2:0]            chan;
    logic                  load_rst;
    logic [1:0]            warm;
    logic                  armed;

`ifdef A2D_RESP_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)                  lfsr <= LFSR_SEED;
        else if (state == FINISH) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    // Out-of-range channels fall through the mux as zero.
    function automatic logic [FRAME_BITS-1:0] ch_word(input logic [2:0] ch);
        logic [DW-1:0] s;
`ifdef A2D_RESP_NOISE_EN
        logic [DW:0]   sum;
`endif
        s = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch == k[2:0]) s = ana_vals[k*DW +: DW];
`ifdef A2D_RESP_NOISE_EN
        sum = {1'b0, s} + (DW+1)'(lfsr[NOISE_BITS-1:0]);
        s   = sum[DW] ? '1 : sum[DW-1:0];
`endif
        return FRAME_BITS'(s);
    endfunction

    // The sync chain resets high for SS_n, so ss_n_s only means something once
    // it has refilled from the pin; a frame already under way at reset is skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shft   <= '0;
            tx_shft   <= '0;
            chan      <= RST_CH[2:0];
            nxt_word  <= '0;
            load_rst  <= 1'b1;
            warm      <= 2'd0;
            armed     <= 1'b0;
            MISO      <= 1'b0;
            last_cmd  <= '0;
            cmd_vld   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            cmd_vld   <= 1'b0;
            frame_err <= 1'b0;
            MISO      <= (state == SHIFT) ? tx_shft[FRAME_BITS-1] : 1'b0;

            if (warm != 2'd2) warm  <= warm + 2'd1;
            else if (ss_n_s)  armed <= 1'b1;

            if (load_rst) begin
                nxt_word <= ch_word(chan);
                load_rst <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (armed && !ss_n_s) begin
                        state   <= SHIFT;
                        tx_shft <= nxt_word;
                        if (sclk_rise) begin
                            rx_shft <= {rx_shft[FRAME_BITS-2:0], mosi_s};
                            bit_cnt <= 5'd1;
                        end else begin
                            bit_cnt <= 5'd0;
                        end
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shft <= {rx_shft[FRAME_BITS-2:0], mosi_s};
                        if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (sclk_fall) tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
                    if (ss_n_s) begin
                        if (bit_cnt == 5'd16) begin
                            state <= FINISH;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    last_cmd  <= rx_shft;
                    cmd_vld   <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    chan      <= rx_shft[CHAN_MSB:CHAN_LSB];
                    nxt_word  <= ch_word(rx_shft[CHAN_MSB:CHAN_LSB]);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: a mode-0 SPI master at SCLK = clk/32 drives frames.
module tb_a2d_spi_resp;

    localparam int NUM_CH = 6;
    localparam int DW     = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 SS_n = 1'b1;
    logic                 SCLK = 1'b0;
    logic                 MOSI = 1'b0;
    logic                 MISO;
    logic [NUM_CH*DW-1:0] ana_vals = '0;
    logic [15:0]          last_cmd;
    logic                 cmd_vld;
    logic                 frame_err;
    logic [15:0]          frame_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    a2d_spi_resp #(.NUM_CH(NUM_CH), .DW(DW), .RST_CH(0), .NOISE_BITS(2)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ana_vals(ana_vals), .last_cmd(last_cmd), .cmd_vld(cmd_vld),
        .frame_err(frame_err), .frame_cnt(frame_cnt));

    always @(negedge clk) begin
        if (cmd_vld === 1'b1)   vld_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic set_ch(input int k, input logic [DW-1:0] v);
        ana_vals[k*DW +: DW] = v;
    endtask

    // Sends data[nbits-1:0] MSB first, captures MISO at each SCLK rise.
    task automatic spi_xfer(input logic [31:0] data, input int nbits, input bit keep_ss,
                            output logic [31:0] rd);
        rd = '0;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = data[nbits-1];
        repeat (16) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            rd   = {rd[30:0], MISO};
            SCLK = 1'b1;
            repeat (16) @(negedge clk);
            SCLK = 1'b0;
            if (i > 0) MOSI = data[i-1];
            repeat (16) @(negedge clk);
        end
        if (!keep_ss) begin
            SS_n = 1'b1;
            MOSI = 1'b0;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++; if (MISO !== 1'b0)       begin n_bad++; $display("FAIL reset_miso got %b want 0", MISO); end
        n_vec++; if (last_cmd !== 16'h0)  begin n_bad++; $display("FAIL reset_last_cmd got %h want 0000", last_cmd); end
        n_vec++; if (cmd_vld !== 1'b0)    begin n_bad++; $display("FAIL reset_cmd_vld got %b want 0", cmd_vld); end
        n_vec++; if (frame_err !== 1'b0)  begin n_bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_vec++; if (frame_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        int v0;
        v0 = vld_cnt;
        spi_xfer(32'h2000, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0789) begin n_bad++; $display("FAIL basic_rd0 got %h want 0789", rd[15:0]); end
        n_vec++; if (last_cmd !== 16'h2000) begin n_bad++; $display("FAIL basic_cmd0 got %h want 2000", last_cmd); end
        spi_xfer(32'hEFFF, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0123) begin n_bad++; $display("FAIL basic_rd1 got %h want 0123", rd[15:0]); end
        n_vec++; if (last_cmd !== 16'hEFFF) begin n_bad++; $display("FAIL basic_cmd1 got %h want efff", last_cmd); end
        spi_xfer(32'h0000, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0456) begin n_bad++; $display("FAIL basic_rd2 got %h want 0456", rd[15:0]); end
        spi_xfer(32'h0000, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0789) begin n_bad++; $display("FAIL basic_rd3 got %h want 0789", rd[15:0]); end
        n_vec++; if (vld_cnt - v0 !== 4)    begin n_bad++; $display("FAIL basic_vld_cnt got %0d want 4", vld_cnt - v0); end
        n_vec++; if (frame_cnt !== 16'd4)   begin n_bad++; $display("FAIL basic_frame_cnt got %0d want 4", frame_cnt); end
    endtask

    task automatic test_frame_err();
        logic [31:0] rd;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        spi_xfer(32'h0010, 7, 1'b0, rd);
        n_vec++; if (err_cnt - e0 !== 1)    begin n_bad++; $display("FAIL ferr_pulse got %0d want 1", err_cnt - e0); end
        n_vec++; if (vld_cnt - v0 !== 0)    begin n_bad++; $display("FAIL ferr_no_vld got %0d want 0", vld_cnt - v0); end
        n_vec++; if (frame_cnt !== 16'd4)   begin n_bad++; $display("FAIL ferr_frame_cnt got %0d want 4", frame_cnt); end
        n_vec++; if (last_cmd !== 16'h0000) begin n_bad++; $display("FAIL ferr_last_cmd got %h want 0000", last_cmd); end
        spi_xfer(32'h2000, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0789) begin n_bad++; $display("FAIL ferr_next_rd got %h want 0789", rd[15:0]); end
        n_vec++; if (frame_cnt !== 16'd5)   begin n_bad++; $display("FAIL ferr_frame_cnt2 got %0d want 5", frame_cnt); end
    endtask

    task automatic test_bad_chan();
        logic [31:0] rd;
        spi_xfer(32'h3800, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0123) begin n_bad++; $display("FAIL badch_rd0 got %h want 0123", rd[15:0]); end
        n_vec++; if (last_cmd !== 16'h3800) begin n_bad++; $display("FAIL badch_cmd got %h want 3800", last_cmd); end
        spi_xfer(32'h3000, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0000) begin n_bad++; $display("FAIL badch_ch7 got %h want 0000", rd[15:0]); end
        spi_xfer(32'h0000, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0000) begin n_bad++; $display("FAIL badch_ch6 got %h want 0000", rd[15:0]); end
        n_vec++; if (frame_cnt !== 16'd8)   begin n_bad++; $display("FAIL badch_frame_cnt got %0d want 8", frame_cnt); end
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        spi_xfer(32'h000F_2000, 20, 1'b0, rd);
        n_vec++; if (rd[19:4] !== 16'h0789) begin n_bad++; $display("FAIL ovr_rd got %h want 0789", rd[19:4]); end
        n_vec++; if (last_cmd !== 16'h2000) begin n_bad++; $display("FAIL ovr_cmd got %h want 2000", last_cmd); end
        n_vec++; if (frame_cnt !== 16'd9)   begin n_bad++; $display("FAIL ovr_frame_cnt got %0d want 9", frame_cnt); end
        spi_xfer(32'h0000, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0123) begin n_bad++; $display("FAIL ovr_next_rd got %h want 0123", rd[15:0]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int e0;
        set_ch(5, 12'hFFF);
        e0 = err_cnt;
        spi_xfer(32'h2800, 9, 1'b1, rd);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (frame_cnt !== 16'h0)  begin n_bad++; $display("FAIL rmid_frame_cnt got %h want 0000", frame_cnt); end
        n_vec++; if (last_cmd !== 16'h0)   begin n_bad++; $display("FAIL rmid_last_cmd got %h want 0000", last_cmd); end
        n_vec++; if (MISO !== 1'b0)        begin n_bad++; $display("FAIL rmid_miso got %b want 0", MISO); end
        n_vec++; if (cmd_vld !== 1'b0)     begin n_bad++; $display("FAIL rmid_cmd_vld got %b want 0", cmd_vld); end
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        spi_xfer(32'h2800, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0789) begin n_bad++; $display("FAIL rmid_rd0 got %h want 0789", rd[15:0]); end
        n_vec++; if (frame_cnt !== 16'd1)   begin n_bad++; $display("FAIL rmid_frame_cnt1 got %0d want 1", frame_cnt); end
        spi_xfer(32'h0000, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0FFF) begin n_bad++; $display("FAIL rmid_rd1 got %h want 0fff", rd[15:0]); end
        n_vec++; if (err_cnt - e0 !== 0)    begin n_bad++; $display("FAIL rmid_no_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_sample_update();
        logic [31:0] rd;
        set_ch(0, 12'h111);
        fork
            spi_xfer(32'h0000, 16, 1'b0, rd);
            begin
                repeat (300) @(negedge clk);
                set_ch(0, 12'h222);
            end
        join
        n_vec++; if (rd[15:0] !== 16'h0789) begin n_bad++; $display("FAIL upd_rd0 got %h want 0789", rd[15:0]); end
        spi_xfer(32'h0000, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0222) begin n_bad++; $display("FAIL upd_rd1 got %h want 0222", rd[15:0]); end
    endtask

    task automatic test_noise();
        logic [31:0] rd;
        set_ch(1, 12'hFFF);
        spi_xfer(32'h0800, 16, 1'b0, rd);
        spi_xfer(32'h0800, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0FFF) begin n_bad++; $display("FAIL noise_sat got %h want 0fff", rd[15:0]); end
        set_ch(1, 12'h100);
        spi_xfer(32'h0800, 16, 1'b0, rd);
        n_vec++; if (rd[15:0] !== 16'h0FFF) begin n_bad++; $display("FAIL noise_sat2 got %h want 0fff", rd[15:0]); end
        spi_xfer(32'h0800, 16, 1'b0, rd);
        n_vec++;
        if (rd[15:0] < 16'h0100 || rd[15:0] > 16'h0103) begin
            n_bad++; $display("FAIL noise_range got %h want 0100..0103", rd[15:0]);
        end
    endtask

    initial begin
        set_ch(0, 12'h789);
        set_ch(4, 12'h123);
        set_ch(5, 12'h456);
        test_reset();
`ifdef A2D_RESP_NOISE_EN
        test_noise();
`else
        test_basic();
        test_frame_err();
        test_bad_chan();
        test_overrun();
        test_reset_mid();
        test_sample_update();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
